// File: rtl/tree_walker.sv
// Decision-tree walker: fetches node words from an external one-cycle-latency ROM and
// follows signed feature/threshold comparisons from the root until it reaches a leaf or aborts.
module tree_walker #(
  parameter int NODE_WIDTH   = 120,
  parameter int ADDR_WIDTH   = 10,
  parameter int ROM_DEPTH    = 512,
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_WIDTH   = 64,
  parameter int MAX_DEPTH    = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
  output logic [ADDR_WIDTH-1:0]              rom_addr,
  input  logic [NODE_WIDTH-1:0]              rom_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [15:0]                        out_class,
  output logic [5:0]                         out_depth,
  output logic                               out_err
);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

  state_t                       state_q;
  logic [ADDR_WIDTH-1:0]        rom_addr_q;
  logic [5:0]                   depth_q;
  logic                         out_valid_q;
  logic [15:0]                  out_class_q;
  logic [5:0]                   out_depth_q;
  logic                         out_err_q;
  logic signed [FEAT_WIDTH-1:0] feat_q  [NUM_FEATURES];
  logic signed [FEAT_WIDTH-1:0] feat_in [NUM_FEATURES];

  generate
    for (genvar gi = 0; gi < NUM_FEATURES; gi++) begin : g_unpack
      assign feat_in[gi] = features[gi*FEAT_WIDTH +: FEAT_WIDTH];
    end
  endgenerate

  // Node word fields
  logic                         node_leaf;
  logic [3:0]                   node_idx;
  logic signed [FEAT_WIDTH-1:0] node_thr;
  logic [9:0]                   node_left;
  logic [9:0]                   node_right;
  logic [15:0]                  node_class;
  logic                         unused_bits;

  assign node_leaf   = rom_data[107];
  assign node_idx    = rom_data[103:100];
  assign node_thr    = rom_data[36 +: FEAT_WIDTH];
  assign node_left   = rom_data[35:26];
  assign node_right  = rom_data[25:16];
  assign node_class  = rom_data[15:0];
  assign unused_bits = ^{rom_data[NODE_WIDTH-1:108], rom_data[106:104]};

  logic signed [FEAT_WIDTH-1:0] feat_sel_d;
  logic [9:0]                   child_d;
  logic                         abort_d;

  // Select by comparison rather than indexing so an out-of-range index never reads past feat_q.
  always_comb begin
    feat_sel_d = '0;
    for (int k = 0; k < NUM_FEATURES; k++) begin
      if (node_idx == 4'(k)) feat_sel_d = feat_q[k];
    end
    child_d = (feat_sel_d <= node_thr) ? node_left : node_right;
    abort_d = (32'(depth_q) == MAX_DEPTH) ||
              (32'(node_idx) >= NUM_FEATURES) ||
              (32'(child_d) >= ROM_DEPTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      depth_q     <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_depth_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_FEATURES; k++) feat_q[k] <= feat_in[k];
            rom_addr_q <= '0;
            depth_q    <= '0;
            state_q    <= WAIT;
          end
        end
        WAIT: state_q <= EVAL;
        EVAL: begin
          if (node_leaf) begin
            out_class_q <= node_class;
            out_depth_q <= depth_q;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (abort_d) begin
            // Abort leaves rom_addr pointing at the offending node.
            out_class_q <= '0;
            out_depth_q <= depth_q;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            rom_addr_q <= ADDR_WIDTH'(child_d);
            depth_q    <= depth_q + 6'd1;
            state_q    <= WAIT;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
  assign out_depth = out_depth_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_tree_walker.sv
// Randomized and directed bench for tree_walker: a path-walking reference model over the
// same ROM image predicts class, depth, error, latency and the address sequence.
module tb_tree_walker;

  localparam int FW = 64;
  localparam int NF = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, out_ready, sel;
  logic [NF*FW-1:0] features;
  logic [119:0]  rom_mem [512];

  // Main build (16 features) and a 15-feature build, selected by sel
  logic         iv16, iv15, or16, or15;
  logic         ir16, ir15, ov16, ov15, oe16, oe15;
  logic [9:0]   ra16, ra15;
  logic [119:0] rd16, rd15;
  logic [15:0]  oc16, oc15;
  logic [5:0]   od16, od15;

  assign iv16 = in_valid & ~sel;
  assign iv15 = in_valid & sel;
  assign or16 = out_ready & ~sel;
  assign or15 = out_ready & sel;

  tree_walker u_dut (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .features(features),
    .rom_addr(ra16), .rom_data(rd16), .out_valid(ov16), .out_ready(or16),
    .out_class(oc16), .out_depth(od16), .out_err(oe16)
  );

  tree_walker #(.NUM_FEATURES(15)) u_dut15 (
    .clk(clk), .rst(rst), .in_valid(iv15), .in_ready(ir15), .features(features[15*FW-1:0]),
    .rom_addr(ra15), .rom_data(rd15), .out_valid(ov15), .out_ready(or15),
    .out_class(oc15), .out_depth(od15), .out_err(oe15)
  );

  always @(posedge clk) begin
    rd16 <= rom_mem[ra16[8:0]];
    rd15 <= rom_mem[ra15[8:0]];
  end

  logic        o_ready, o_valid, o_err;
  logic [9:0]  o_addr;
  logic [15:0] o_class;
  logic [5:0]  o_depth;
  assign o_ready = sel ? ir15 : ir16;
  assign o_valid = sel ? ov15 : ov16;
  assign o_err   = sel ? oe15 : oe16;
  assign o_addr  = sel ? ra15 : ra16;
  assign o_class = sel ? oc15 : oc16;
  assign o_depth = sel ? od15 : od16;

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  logic [15:0] exp_cls;
  int          exp_depth;
  logic        exp_err;
  int          exp_path [64];
  logic [15:0] obs_cls;
  int          obs_depth, obs_lat;
  logic        obs_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rand_feat();
    int v;
    logic signed [63:0] s;
    case ($urandom_range(0, 3))
      0: rand_feat = {$urandom(), $urandom()};
      1: begin v = int'($urandom_range(0, 16)) - 8; s = 64'(v); rand_feat = s; end
      2: rand_feat = ($urandom_range(0, 1) != 0) ? 64'h8000_0000_0000_0000 : 64'h7fff_ffff_ffff_ffff;
      default: begin v = int'($urandom_range(0, 4)) - 2; s = 64'(v); rand_feat = s; end
    endcase
  endfunction

  function automatic logic [NF*FW-1:0] rand_vec();
    logic [NF*FW-1:0] v;
    for (int k = 0; k < NF; k++) v[k*FW +: FW] = rand_feat();
    return v;
  endfunction

  function automatic logic [119:0] mk_node(input logic leaf, input int idx, input logic [63:0] thr,
                                           input int left, input int right, input logic [15:0] cls);
    logic [119:0] n;
    n = '0;
    n[107]     = leaf;
    n[103:100] = 4'(idx);
    n[99:36]   = thr;
    n[35:26]   = 10'(left);
    n[25:16]   = 10'(right);
    n[15:0]    = cls;
    return n;
  endfunction

  task automatic clear_rom();
    for (int a = 0; a < 512; a++) rom_mem[a] = '0;
  endtask

  task automatic random_rom();
    logic [119:0] n;
    for (int a = 0; a < 512; a++) begin
      n = {$urandom(), $urandom(), $urandom(), $urandom()};
      n[107]     = ($urandom_range(0, 9) < 3);
      n[99:36]   = rand_feat();
      n[35:26]   = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 63));
      n[25:16]   = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(512, 1023)) : 10'($urandom_range(0, 63));
      rom_mem[a] = n;
    end
  endtask

  // Walk the tree from the root following the node rules directly.
  task automatic ref_walk(input logic [NF*FW-1:0] fv, input int nf);
    int addr, idx, child;
    logic [119:0] node;
    logic signed [63:0] f, thr;
    addr = 0; exp_depth = 0; exp_err = 1'b0; exp_cls = '0; exp_path[0] = 0;
    for (int step = 0; step <= 40; step++) begin
      node = rom_mem[addr];
      if (node[107]) begin exp_cls = node[15:0]; break; end
      idx = int'(node[103:100]);
      if (exp_depth == 32 || idx >= nf) begin exp_err = 1'b1; break; end
      f     = fv[idx*FW +: FW];
      thr   = node[99:36];
      child = (f <= thr) ? int'(node[35:26]) : int'(node[25:16]);
      if (child >= 512) begin exp_err = 1'b1; break; end
      addr = child;
      exp_depth++;
      exp_path[exp_depth] = child;
    end
  endtask

  // Entered and left at posedge+1 with the selected DUT idle.
  task automatic run_one(input logic [NF*FW-1:0] fv, input int hold);
    int c;
    logic path_ok, stable_ok;
    ref_walk(fv, sel ? 15 : 16);
    check("in_ready_idle", o_ready, 1);
    features = fv;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    path_ok = 1'b1;
    while (!o_valid && c < 100) begin
      if (c % 2 == 0) begin
        if (c / 2 > exp_depth || o_addr != 10'(exp_path[c/2])) path_ok = 1'b0;
      end
      in_valid = 1'($urandom_range(0, 1));
      features = rand_vec();
      @(posedge clk); #1;
      c++;
    end
    obs_lat = c; obs_cls = o_class; obs_depth = int'(o_depth); obs_err = o_err;
    check("latency", c, 2 * (exp_depth + 1));
    check("out_class", o_class, exp_cls);
    check("out_depth", o_depth, exp_depth);
    check("out_err", o_err, exp_err);
    check("addr_seq", path_ok, 1);
    check("in_ready_done", o_ready, 0);
    stable_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      features = rand_vec();
      @(posedge clk); #1;
      if (!o_valid || o_ready || o_class != exp_cls || int'(o_depth) != exp_depth || o_err != exp_err)
        stable_ok = 1'b0;
    end
    check("hold_stable", stable_ok, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", {o_valid, o_ready}, 2'b01);
    n_txn++;
    $display("[TB] txn %0d nf=%0d depth=%0d class=%04h err=%0d lat=%0d hold=%0d",
             n_txn, sel ? 15 : 16, obs_depth, obs_cls, obs_err, obs_lat, hold);
  endtask

  initial begin
    logic [NF*FW-1:0] fv;
    logic [63:0] fa [4];
    logic [63:0] ta [4];
    logic never_valid;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 1'b0; features = '0;
    clear_rom();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", ir16, 1);
    check("rst_out_valid", ov16, 0);
    check("rst_rom_addr", ra16, 0);
    check("rst_out_class", oc16, 0);
    check("rst_out_depth", od16, 0);
    check("rst_out_err", oe16, 0);

    // Root is a leaf
    rom_mem[0] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0001);
    run_one(rand_vec(), 0);
    check("root_leaf_lat", obs_lat, 2);
    check("root_leaf_class", obs_cls, 16'h0001);

    // Three levels, equality then negative feature: left, left
    clear_rom();
    rom_mem[0] = mk_node(1'b0, 1, 64'd192, 5, 6, 16'h0);
    rom_mem[5] = mk_node(1'b0, 3, 64'd10, 7, 8, 16'h0);
    rom_mem[6] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0006);
    rom_mem[7] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'hABCD);
    rom_mem[8] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0008);
    fv = rand_vec();
    fv[1*FW +: FW] = 64'd192;
    fv[3*FW +: FW] = 64'hFFFF_FFFF_FFFF_FFFB;
    run_one(fv, 2);
    check("lvl3_class", obs_cls, 16'hABCD);
    check("lvl3_lat", obs_lat, 6);

    // Self-loop runs into the depth limit
    clear_rom();
    run_one(rand_vec(), 1);
    check("loop_err", obs_err, 1);
    check("loop_depth", obs_depth, 32);
    check("loop_lat", obs_lat, 66);

    // Child address beyond the ROM
    rom_mem[0] = mk_node(1'b0, 0, 64'd0, 700, 700, 16'h0);
    run_one(rand_vec(), 0);
    check("badaddr_err", obs_err, 1);

    // Extreme signed values
    rom_mem[0] = mk_node(1'b0, 2, 64'd0, 1, 2, 16'h0);
    rom_mem[1] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0011);
    rom_mem[2] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0022);
    fa[0] = 64'h8000_0000_0000_0000; ta[0] = 64'h7fff_ffff_ffff_ffff;
    fa[1] = 64'h7fff_ffff_ffff_ffff; ta[1] = 64'h8000_0000_0000_0000;
    fa[2] = 64'h8000_0000_0000_0000; ta[2] = 64'h8000_0000_0000_0000;
    fa[3] = 64'h0000_0000_0000_0000; ta[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      rom_mem[0][99:36] = ta[i];
      fv = rand_vec();
      fv[2*FW +: FW] = fa[i];
      run_one(fv, 0);
    end

    // Long backpressure in DONE
    run_one(rand_vec(), 10);

    // Feature index 15 on both builds
    rom_mem[0] = mk_node(1'b0, 15, 64'd0, 1, 2, 16'h0);
    sel = 1'b1;
    run_one(rand_vec(), 0);
    check("idx15_nf15_err", obs_err, 1);
    check("idx15_nf15_class", obs_cls, 0);
    sel = 1'b0;
    run_one(rand_vec(), 0);
    check("idx15_nf16_err", obs_err, 0);

    // Reset in WAIT at depth 3, with in_valid also high
    clear_rom();
    for (int a = 0; a < 4; a++) rom_mem[a] = mk_node(1'b0, 0, 64'h7fff_ffff_ffff_ffff, a + 1, a + 1, 16'h0);
    rom_mem[4] = mk_node(1'b1, 0, 64'd0, 0, 0, 16'h0044);
    features = rand_vec();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("rst_mid_addr", ra16, 3);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_mid_ready", ir16, 1);
    check("rst_mid_addr0", ra16, 0);
    never_valid = 1'b1;
    repeat (10) begin @(posedge clk); #1; if (ov16) never_valid = 1'b0; end
    check("rst_mid_no_valid", never_valid, 1);
    run_one(rand_vec(), 0);
    check("rst_mid_next_class", obs_cls, 16'h0044);

    // Random trees on both builds
    for (int r = 0; r < 6; r++) begin
      random_rom();
      for (int t = 0; t < 25; t++) begin
        sel = ($urandom_range(0, 3) == 0);
        run_one(rand_vec(), int'($urandom_range(0, 3)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
